// File: rtl/div_issue_ctrl_pkg.sv
// div_issue_ctrl_pkg: operation and controller-state types shared by the
// divide issue controller and anything that talks to it.
package types;
   typedef enum logic [1:0] {DIV = 2'd0, DIVU = 2'd1, REM = 2'd2, REMU = 2'd3} div_op_t;
   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DRAIN} ctrl_state_t;
   function automatic logic is_signed(input div_op_t op);
      return op == DIV || op == REM;
   endfunction
   function automatic logic is_rem(input div_op_t op);
      return op[1];
   endfunction
endpackage

// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: issues RV32M divides to an external multi-cycle Divider,
// short-circuits divide-by-zero and repeated operands from a one-entry cache.
module div_issue_ctrl
   import types::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   input  div_op_t     req_op,
   input  logic [31:0] rs1_val,
   input  logic [31:0] rs2_val,
   input  logic [4:0]  req_rd,
   input  logic        flush,
   output logic        div_en,
   output logic [31:0] dividend,
   output logic [31:0] divisor,
   output logic        signed_en,
   input  logic [31:0] quotient,
   input  logic [31:0] remainder,
   input  logic        resp,
   output logic        stall,
   output logic        wb_valid,
   output logic [31:0] wb_data,
   output logic [4:0]  wb_rd
);
   ctrl_state_t state, state_nx;
   div_op_t     op_q;
   logic [4:0]  rd_q;
   logic [31:0] a_q, b_q;
   logic        sgn_q;
   logic        c_valid, c_sgn;
   logic [31:0] c_a, c_b, c_q, c_r;
   logic        take, hit, zero_path, hit_path, accept, fill;

   assign take      = rst_n && state == IDLE && req_valid && !flush;
   assign hit       = c_valid && rs1_val == c_a && rs2_val == c_b && is_signed(req_op) == c_sgn;
   assign zero_path = take && rs2_val == '0;
   assign hit_path  = take && rs2_val != '0 && hit;
   assign accept    = take && rs2_val != '0 && !hit;
   assign fill      = rst_n && resp && (state == WAIT || state == DRAIN);
   assign dividend  = a_q;
   assign divisor   = b_q;
   assign signed_en = sgn_q;

   always_comb begin
      state_nx = state;
      div_en   = 1'b0;
      stall    = 1'b0;
      wb_valid = 1'b0;
      wb_data  = '0;
      wb_rd    = rd_q;
      case (state)
         IDLE: begin
            if (zero_path) begin
               wb_valid = 1'b1;
               wb_data  = is_rem(req_op) ? rs1_val : '1;
               wb_rd    = req_rd;
            end else if (hit_path) begin
               wb_valid = 1'b1;
               wb_data  = is_rem(req_op) ? c_r : c_q;
               wb_rd    = req_rd;
            end else if (accept) begin
               stall    = 1'b1;
               state_nx = LAUNCH;
            end
         end
         LAUNCH: begin
            div_en   = 1'b1;
            stall    = 1'b1;
            state_nx = flush ? DRAIN : WAIT;
         end
         WAIT: begin
            if (resp) begin
               wb_valid = !flush;
               wb_data  = is_rem(op_q) ? remainder : quotient;
               state_nx = IDLE;
            end else begin
               stall    = 1'b1;
               state_nx = flush ? DRAIN : WAIT;
            end
         end
         DRAIN: begin
            stall    = req_valid;
            state_nx = resp ? IDLE : DRAIN;
         end
      endcase
      // outputs must drop the moment reset asserts, not at the next edge
      if (!rst_n) begin
         div_en   = 1'b0;
         stall    = 1'b0;
         wb_valid = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         op_q    <= DIV;
         rd_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sgn_q   <= 1'b0;
         c_valid <= 1'b0;
         c_sgn   <= 1'b0;
         c_a     <= '0;
         c_b     <= '0;
         c_q     <= '0;
         c_r     <= '0;
      end else begin
         state <= state_nx;
         if (accept) begin
            op_q  <= req_op;
            rd_q  <= req_rd;
            a_q   <= rs1_val;
            b_q   <= rs2_val;
            sgn_q <= is_signed(req_op);
         end
         if (fill) begin
            c_valid <= 1'b1;
            c_a     <= a_q;
            c_b     <= b_q;
            c_sgn   <= sgn_q;
            c_q     <= quotient;
            c_r     <= remainder;
         end
      end
   end
endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb_div_issue_ctrl: directed and randomized checks of the divide issue
// controller against an arithmetic reference and a one-entry cache model.
module tb_div_issue_ctrl;
   import types::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   div_op_t     req_op;
   logic [31:0] rs1_val, rs2_val;
   logic [4:0]  req_rd;
   logic        flush;
   logic        div_en;
   logic [31:0] dividend, divisor;
   logic        signed_en;
   logic [31:0] quotient, remainder;
   logic        resp;
   logic        stall, wb_valid;
   logic [31:0] wb_data;
   logic [4:0]  wb_rd;

   int nvec = 0;
   int nfail = 0;
   int pulses = 0;
   int lat = 2;
   logic [3:0] cnt;

   bit          m_valid = 1'b0;
   bit          m_s;
   logic [31:0] m_a, m_b;

   always #5 clk = ~clk;

   div_issue_ctrl dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op),
      .rs1_val(rs1_val), .rs2_val(rs2_val), .req_rd(req_rd), .flush(flush),
      .div_en(div_en), .dividend(dividend), .divisor(divisor), .signed_en(signed_en),
      .quotient(quotient), .remainder(remainder), .resp(resp), .stall(stall),
      .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd)
   );

   function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
      if (b == 0) return {32'hFFFF_FFFF, a};
      if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {a, 32'h0};
      if (s) return {32'($signed(a) / $signed(b)), 32'($signed(a) % $signed(b))};
      return {a / b, a % b};
   endfunction

   // Divider stand-in: result after lat cycles, computed from the operands it sees at completion
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt <= '0;
      else if (div_en) cnt <= 4'(lat);
      else if (cnt != 0) cnt <= cnt - 4'd1;
   end
   assign resp = cnt == 4'd1;
   assign {quotient, remainder} = ref_div(dividend, divisor, signed_en);

   always @(posedge clk) if (div_en) pulses++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic run_req(input div_op_t op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input int fl_at, input int rst_at,
                          input bit nrv, input div_op_t nop);
      logic [63:0] res;
      logic [31:0] exp_d;
      bit s, fast, drained, done;
      int p0;
      @(posedge clk); #1;
      req_valid = 1'b1; req_op = op; rs1_val = a; rs2_val = b; req_rd = rd;
      flush = fl_at == 0;
      s = op == DIV || op == REM;
      res = ref_div(a, b, s);
      exp_d = (op == REM || op == REMU) ? res[31:0] : res[63:32];
      fast = b == 0 || (m_valid && a == m_a && b == m_b && s == m_s);
      p0 = pulses;
      #4;
      if (fl_at == 0) begin
         chk("idle_flush_wb_valid", 32'(wb_valid), 0);
         chk("idle_flush_stall", 32'(stall), 0);
         chk("idle_flush_div_en", 32'(div_en), 0);
         return;
      end
      if (fast) begin
         chk("fast_wb_valid", 32'(wb_valid), 1);
         chk("fast_stall", 32'(stall), 0);
         chk("fast_div_en", 32'(div_en), 0);
         chk("fast_wb_data", wb_data, exp_d);
         chk("fast_wb_rd", 32'(wb_rd), 32'(rd));
         return;
      end
      chk("accept_stall", 32'(stall), 1);
      chk("accept_wb_valid", 32'(wb_valid), 0);
      chk("accept_div_en", 32'(div_en), 0);
      drained = 0;
      done = 0;
      for (int c = 1; c <= 40 && !done; c++) begin
         @(posedge clk); #1;
         if (drained) begin req_valid = nrv; req_op = nop; end
         flush = c == fl_at;
         if (c == rst_at) begin
            rst_n = 1'b0;
            #1;
            chk("rst_div_en", 32'(div_en), 0);
            chk("rst_stall", 32'(stall), 0);
            chk("rst_wb_valid", 32'(wb_valid), 0);
            m_valid = 0;
            req_valid = 1'b0;
            flush = 1'b0;
            return;
         end
         #4;
         chk("held_dividend", dividend, a);
         chk("held_divisor", divisor, b);
         chk("held_signed_en", 32'(signed_en), 32'(s));
         if (c == 1) begin
            chk("launch_div_en", 32'(div_en), 1);
            chk("launch_stall", 32'(stall), 1);
            chk("launch_wb_valid", 32'(wb_valid), 0);
            drained = flush;
         end else begin
            chk("wait_div_en", 32'(div_en), 0);
            if (drained) begin
               chk("drain_stall", 32'(stall), 32'(req_valid));
               chk("drain_wb_valid", 32'(wb_valid), 0);
            end else if (resp) begin
               chk("resp_stall", 32'(stall), 0);
               chk("resp_wb_valid", 32'(wb_valid), 32'(!flush));
               if (!flush) begin
                  chk("resp_wb_data", wb_data, exp_d);
                  chk("resp_wb_rd", 32'(wb_rd), 32'(rd));
               end
            end else begin
               chk("wait_stall", 32'(stall), 1);
               chk("wait_wb_valid", 32'(wb_valid), 0);
               drained = flush;
            end
            if (resp) begin
               m_valid = 1; m_a = a; m_b = b; m_s = s;
               done = 1;
            end
         end
      end
      chk("resp_seen", 32'(done), 1);
      chk("div_en_pulses", 32'(pulses - p0), 1);
   endtask

   task automatic idle();
      @(posedge clk); #1;
      req_valid = 1'b0;
      flush = 1'b0;
   endtask

   div_op_t     r_op, n_op;
   logic [31:0] r_a, r_b;
   bit          carry;

   function automatic logic [31:0] pick(input logic [31:0] prev, input bit allow_zero);
      case ($urandom_range(0, 4))
         0: return $urandom;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return prev;
         default: return allow_zero ? 32'($urandom_range(0, 9)) : 32'($urandom_range(1, 9));
      endcase
   endfunction

   initial begin
      rst_n = 1'b0; req_valid = 1'b1; req_op = DIV; rs1_val = 32'd40; rs2_val = 32'd5;
      req_rd = 5'd3; flush = 1'b0;
      #12;
      chk("reset_div_en", 32'(div_en), 0);
      chk("reset_stall", 32'(stall), 0);
      chk("reset_wb_valid", 32'(wb_valid), 0);
      chk("reset_wb_rd", 32'(wb_rd), 0);
      chk("reset_dividend", dividend, 0);
      chk("reset_divisor", divisor, 0);
      chk("reset_signed_en", 32'(signed_en), 0);
      @(posedge clk); #1;
      rst_n = 1'b1; req_valid = 1'b0;

      lat = 3;
      run_req(DIV, 32'hFFFF_FFF9, 32'd2, 5'd5, -1, -1, 0, DIV);
      chk("dir_div_neg7_by_2", wb_data, 32'hFFFF_FFFD);
      run_req(REM, 32'hFFFF_FFF9, 32'd2, 5'd6, -1, -1, 0, REM);
      chk("dir_rem_hit", wb_data, 32'hFFFF_FFFF);
      run_req(DIVU, 32'd100, 32'd7, 5'd7, -1, -1, 0, DIVU);
      chk("dir_divu_100_7", wb_data, 32'd14);
      run_req(DIV, 32'd100, 32'd7, 5'd8, -1, -1, 0, DIV);
      chk("dir_div_100_7", wb_data, 32'd14);
      run_req(REM, 32'hFFFF_FFF9, 32'd0, 5'd9, -1, -1, 0, REM);
      chk("dir_rem_by_zero", wb_data, 32'hFFFF_FFF9);
      run_req(DIV, 32'hFFFF_FFF9, 32'd0, 5'd10, -1, -1, 0, DIV);
      chk("dir_div_by_zero", wb_data, 32'hFFFF_FFFF);
      lat = 5;
      run_req(DIVU, 32'd1000, 32'd3, 5'd11, 3, -1, 1, REMU);
      run_req(REMU, 32'd1000, 32'd3, 5'd12, -1, -1, 0, REMU);
      chk("dir_remu_after_drain", wb_data, 32'd1);
      lat = 2;
      run_req(REM, 32'd9, 32'd4, 5'd13, -1, -1, 0, REM);
      lat = 6;
      run_req(DIVU, 32'd50, 32'd6, 5'd14, -1, 2, 0, DIVU);
      @(posedge clk); #1;
      rst_n = 1'b1;
      lat = 2;
      run_req(REM, 32'd9, 32'd4, 5'd15, -1, -1, 0, REM);
      chk("dir_rem_after_reset", wb_data, 32'd1);
      idle();

      r_a = 32'd17; r_b = 32'd3; carry = 0; n_op = DIV;
      for (int i = 0; i < 60; i++) begin
         int fl, sel;
         bit nrv;
         if (carry) r_op = n_op;
         else begin
            r_op = div_op_t'($urandom_range(0, 3));
            r_a = pick(r_a, 1);
            r_b = pick(r_b, 1);
         end
         lat = $urandom_range(1, 6);
         sel = $urandom_range(0, 9);
         fl = sel < 6 ? -1 : sel == 6 ? 0 : $urandom_range(1, lat + 1);
         nrv = 1'($urandom_range(0, 1));
         n_op = div_op_t'($urandom_range(0, 3));
         run_req(r_op, r_a, r_b, 5'($urandom), fl, -1, nrv, n_op);
         carry = fl > 0 && nrv;
         if (!carry && $urandom_range(0, 3) == 0) idle();
      end
      idle();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1);
   end
endmodule

// File: doc/div_issue_ctrl.md
DIV_ISSUE_CTRL -- requirements
Module: div_issue_ctrl

Interface
REQ-001 SHALL have exactly one clock and one reset: the clock is clk; the reset is rst_n, asynchronous and active-low.
REQ-002 SHALL have these ports (name, direction, width, meaning):
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  EX holds an RV32M DIV/DIVU/REM/REMU
- req_op  in  div_op_t (2)  DIV, DIVU, REM or REMU
- rs1_val  in  32  dividend
- rs2_val  in  32  divisor
- req_rd  in  5  destination register
- flush  in  1  squash the in-flight instruction
- div_en  out  1  one-cycle launch strobe to the Divider
- dividend  out  32  operand to the Divider
- divisor  out  32  operand to the Divider
- signed_en  out  1  signed division, to the Divider
- quotient  in  32  from the Divider
- remainder  in  32  from the Divider
- resp  in  1  Divider result valid
- stall  out  1  freeze IF/ID/EX
- wb_valid  out  1  result valid this cycle
- wb_data  out  32  result
- wb_rd  out  5  destination of the result

Function
REQ-003 SHALL run a state machine with states IDLE, LAUNCH, WAIT and DRAIN.
REQ-004 In IDLE with req_valid=1 and flush=0, SHALL take a fast path when rs2_val=0:
- wb_valid=1 and stall=0 in the same cycle;
- wb_data = 0xFFFFFFFF for DIV/DIVU;
- wb_data = rs1_val for REM/REMU;
- no div_en.
REQ-005 In IDLE with req_valid=1 and flush=0, SHALL take a fast path on a cache hit:
- hit = cache valid, and rs1_val, rs2_val and signedness all equal the stored values;
- wb_valid=1 in the same cycle, with wb_data = cached quotient or remainder selected by req_op;
- stall=0 and no div_en.
REQ-006 Otherwise, SHALL accept the request in IDLE:
- register rs1_val, rs2_val, signedness (DIV/REM), req_op and req_rd;
- assert stall=1 combinationally in that cycle;
- go to LAUNCH.
REQ-007 In LAUNCH, SHALL drive div_en=1 for exactly one cycle, with the registered operands, then go to WAIT.
REQ-008 SHALL hold dividend, divisor and signed_en stable from LAUNCH through the resp cycle, because the Divider re-reads them at completion.
REQ-009 SHALL hold stall=1 from the accept cycle up to, but not including, the resp cycle.
REQ-010 In WAIT with resp=1:
- stall=0 and wb_valid=1;
- wb_data = quotient for DIV/DIVU, remainder for REM/REMU; wb_rd = registered rd;
- cache filled with operands, signedness, quotient and remainder;
- next state IDLE.
REQ-011 SHALL ignore req_valid while in LAUNCH and WAIT.
REQ-012 flush in LAUNCH SHALL still complete the div_en pulse, then go to DRAIN.
REQ-013 flush in WAIT without resp SHALL go to DRAIN.
REQ-014 flush in WAIT together with resp SHALL suppress wb_valid, still fill the cache, and go to IDLE.
REQ-015 flush in IDLE SHALL block acceptance and the fast paths.
REQ-016 In DRAIN:
- stall = req_valid, and no request is accepted;
- on resp, fill the cache, keep wb_valid=0, and go to IDLE.
REQ-017 SHALL accept a new request, at the earliest, in the cycle after the resp cycle.
REQ-018 wb_valid SHALL never be asserted in two consecutive cycles for the same instruction.

Reset
REQ-019 While rst_n=0, SHALL force:
- state to IDLE;
- div_en, stall and wb_valid to 0;
- cache valid to 0;
- all registered operands and wb_rd to 0.
REQ-020 Reset mid-WAIT SHALL abandon the operation; the Divider SHALL be reset in the same cycle by the integrator (Divider rst = ~rst_n).

Structure
REQ-021 SHALL place div_op_t (DIV=0, DIVU=1, REM=2, REMU=3) and the controller state enum in package types.
REQ-022 SHALL contain no sub-modules; the Divider is instantiated beside this block by the parent.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- DIV rs1=0xFFFFFFF9 (-7), rs2=2 -> single div_en pulse, stall until resp, wb_data=0xFFFFFFFD.
- REM, same operands immediately after -> cache hit, wb_valid in the same cycle, stall=0, wb_data=0xFFFFFFFF, no div_en.
- DIVU 100/7, then DIVU 100/7 signed change to DIV 100/7 -> first wb_data=14; the second launches a new division (signedness mismatch), wb_data=14.
- REM rs1=0xFFFFFFF9, rs2=0 -> wb_data=0xFFFFFFF9 in the same cycle, div_en never asserted; DIV -> 0xFFFFFFFF.
- DIVU 1000/3 with flush in the second WAIT cycle -> DRAIN, wb_valid stays 0, a following request is stalled until resp, then REMU 1000/3 hits the cache, wb_data=1.
- rst_n low during WAIT -> div_en/stall/wb_valid=0 immediately, next REM 9/4 launches (cache invalid), wb_data=1.
